div_sign_ctrl: RTL and testbench

Signed/unsigned front-end sequencer for the RV32M divide path. It sits between the M-extension issue logic and the unsigned iterative divider core. Per request it:
- decodes DIV/DIVU/REM/REMU;
- resolves divide-by-zero and signed overflow without the core;
- converts signed operands to magnitudes and drives the core over its valid/done handshake;
- sign-corrects the returned quotient or remainder and holds the result until the consumer accepts it.

---
 rtl/div_sign_ctrl.sv | 172 +++++++++++++++++
 tb/tb_div_sign_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sign_ctrl.sv
`timescale 1ns/1ps
// div_sign_ctrl: signed/unsigned front-end sequencer between RV32M issue and the unsigned divider core.
// Optional build macro DIV_SMALL_BYPASS_EN: answer |a| < |b| requests without the core.
module div_sign_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      req_op,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   input  logic            flush,
   output logic            core_valid,
   output logic [XLEN-1:0] core_a,
   output logic [XLEN-1:0] core_b,
   input  logic [XLEN-1:0] core_q,
   input  logic [XLEN-1:0] core_r,
   input  logic            core_done,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP,
      S_DRAIN
   } state_t;

   localparam logic [XLEN-1:0] ALL_ONES = '1;
   localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   // Two's-complement negate when requested; self-inverse, so it serves both
   // magnitude extraction and final sign correction.
   function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] val,
                                                  input logic            neg);
      logic signed [XLEN-1:0] val_s;
      val_s = signed'(val);
      return neg ? unsigned'(-val_s) : val;
   endfunction

   state_t state, state_nx;

   logic            op_signed;
   logic            op_rem;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   logic            div_zero;
   logic            sign_ovf;
   logic            small_hit;
   logic            special;
   logic [XLEN-1:0] special_res;
   logic            accept;

   logic            neg_q;
   logic            neg_r;
   logic            is_rem;
   logic [XLEN-1:0] core_res;

   // Request decode: funct3[0] selects unsigned, funct3[1] selects remainder.
   assign op_signed = ~req_op[0];
   assign op_rem    = req_op[1];
   assign a_neg     = op_signed & req_a[XLEN-1];
   assign b_neg     = op_signed & req_b[XLEN-1];
   assign mag_a     = apply_sign(req_a, a_neg);
   assign mag_b     = apply_sign(req_b, b_neg);
   assign div_zero  = (req_b == '0);
   assign sign_ovf  = op_signed && (req_a == INT_MIN) && (req_b == ALL_ONES);

`ifdef DIV_SMALL_BYPASS_EN
   assign small_hit = (mag_a < mag_b);
`else
   assign small_hit = 1'b0;
`endif

   assign special = div_zero | sign_ovf | small_hit;

   always_comb begin
      special_res = '0;
      if (div_zero) begin
         special_res = op_rem ? req_a : ALL_ONES;
      end else if (sign_ovf) begin
         special_res = op_rem ? '0 : INT_MIN;
      end else if (small_hit) begin
         special_res = op_rem ? req_a : '0;
      end
   end

   assign req_ready  = (state == S_IDLE) && !reset && !flush;
   assign accept     = req_valid && req_ready;
   assign core_valid = (state == S_ISSUE);
   assign rsp_valid  = (state == S_RESP);

   // Core results are unsigned magnitudes; restore the architectural sign.
   assign core_res = is_rem ? apply_sign(core_r, neg_r) : apply_sign(core_q, neg_q);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // flush outranks core_done and rsp_ready; a core that cannot be aborted is drained.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nx = special ? S_RESP : S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_nx = flush ? S_DRAIN : S_WAIT;
         end
         S_WAIT: begin
            if (flush) begin
               state_nx = core_done ? S_IDLE : S_DRAIN;
            end else if (core_done) begin
               state_nx = S_RESP;
            end
         end
         S_RESP: begin
            if (flush || rsp_ready) begin
               state_nx = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (core_done) begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rsp_data <= '0;
         core_a   <= '0;
         core_b   <= '0;
      end else begin
         if (accept) begin
            if (special) begin
               rsp_data <= special_res;
            end else begin
               core_a <= mag_a;
               core_b <= mag_b;
            end
         end
         if ((state == S_WAIT) && core_done && !flush) begin
            rsp_data <= core_res;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         neg_q  <= a_neg ^ b_neg;
         neg_r  <= a_neg;
         is_rem <= op_rem;
      end
   end

endmodule

// File: tb/tb_div_sign_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for div_sign_ctrl: random RV32M divide requests against a plain-arithmetic model.
module tb_div_sign_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic        flush = 1'b0;
   logic        core_valid;
   logic [31:0] core_a;
   logic [31:0] core_b;
   logic [31:0] core_q = '0;
   logic [31:0] core_r = '0;
   logic        core_done = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;

   div_sign_ctrl #(.XLEN(32)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .flush(flush),
      .core_valid(core_valid), .core_a(core_a), .core_b(core_b),
      .core_q(core_q), .core_r(core_r), .core_done(core_done),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: RISC-V M-extension semantics in plain arithmetic.
   function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic signed [31:0] sa, sb;
      logic [31:0] res;
      sa = signed'(a);
      sb = signed'(b);
      case (op)
         2'd0:    res = (b == 0) ? 32'hFFFFFFFF :
                        (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h80000000 : unsigned'(sa / sb);
         2'd1:    res = (b == 0) ? 32'hFFFFFFFF : a / b;
         2'd2:    res = (b == 0) ? a :
                        (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : unsigned'(sa % sb);
         default: res = (b == 0) ? a : a % b;
      endcase
      return res;
   endfunction

   function automatic longint mag_of(input logic [31:0] x, input bit sgn);
      longint v;
      v = sgn ? longint'(signed'(x)) : longint'(x);
      return (v < 0) ? -v : v;
   endfunction

   function automatic bit fast_path(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bit sgn;
      sgn = !op[0];
      if (b == 0) return 1'b1;
      if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1'b1;
`ifdef DIV_SMALL_BYPASS_EN
      if (mag_of(a, sgn) < mag_of(b, sgn)) return 1'b1;
`endif
      return 1'b0;
   endfunction

   // Unsigned core model with programmable latency and stray done strobes when idle.
   int          core_lat = -1;
   bit          core_busy = 1'b0;
   int          core_cnt = 0;
   logic [31:0] lat_a = '0;
   logic [31:0] lat_b = '0;
   int          done_edge = 0;
   int          core_starts = 0;

   always @(negedge clock) begin
      core_done = 1'b0;
      core_q = $urandom;
      core_r = $urandom;
      if (reset) begin
         core_busy = 1'b0;
      end else begin
         if (core_busy) begin
            if (core_cnt == 0) begin
               core_done = 1'b1;
               core_q = (lat_b != 0) ? lat_a / lat_b : 32'hFFFFFFFF;
               core_r = (lat_b != 0) ? lat_a % lat_b : lat_a;
               done_edge = cyc + 1;
               core_busy = 1'b0;
               chk("core_a_hold", core_a, lat_a);
               chk("core_b_hold", core_b, lat_b);
            end else begin
               core_cnt--;
            end
         end else if ($urandom_range(0, 5) == 0) begin
            core_done = 1'b1;
         end
         if (core_valid) begin
            chk("core_start_while_busy", {31'b0, core_busy}, 32'd0);
            chk("core_b_nonzero", {31'b0, (core_b == 0)}, 32'd0);
            lat_a = core_a;
            lat_b = core_b;
            core_busy = 1'b1;
            core_cnt = (core_lat >= 0) ? core_lat : $urandom_range(0, 4);
            core_starts++;
         end
      end
   end

   typedef struct {
      logic [31:0] data;
      int          acc_edge;
      bit          fast;
      int          starts;
      string       tag;
   } exp_t;

   exp_t sb_q[$];
   bit   flush_txn = 1'b0;
   bit   head_seen = 1'b0;
   logic [31:0] held = '0;

   // Monitor: compares every presented response against the scoreboard head.
   always @(negedge clock) begin
      exp_t e;
      if (!reset && rsp_valid) begin
         if (sb_q.size() == 0) begin
            if (!flush_txn) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got rsp_valid with data %h, required no response", rsp_data);
            end
         end else begin
            e = sb_q[0];
            if (!head_seen) begin
               chk({e.tag, " data"}, rsp_data, e.data);
               chk({e.tag, " latency"}, cyc, e.fast ? e.acc_edge : done_edge);
               if (e.fast) chk({e.tag, " core_bypassed"}, core_starts, e.starts);
               head_seen = 1'b1;
               held = rsp_data;
            end else begin
               chk({e.tag, " hold"}, rsp_data, held);
            end
            if (rsp_ready && !flush) begin
               void'(sb_q.pop_front());
               head_seen = 1'b0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // fl_dly < 0: normal transaction; otherwise flush fl_dly cycles after accept.
   task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int fl_dly, input int rdy_dly, input bit pre_flush, input string tag);
      exp_t e;
      int   n;
      int   acc;
      int   fl_edge;
      int   rdy_exp;
      bit   fast;
      bit   saw;
      req_op = op;
      req_a = a;
      req_b = b;
      req_valid = 1'b1;
      if (pre_flush) begin
         flush = 1'b1;
         #1;
         chk({tag, " flush_blocks_accept"}, {31'b0, req_ready}, 32'd0);
         step();
         flush = 1'b0;
      end
      #1;
      n = 0;
      while (!req_ready && n < 100) begin
         step();
         n++;
      end
      if (!req_ready) begin
         chk({tag, " accept_timeout"}, {31'b0, req_ready}, 32'd1);
         req_valid = 1'b0;
         return;
      end
      acc = cyc + 1;
      step();
      req_valid = 1'b0;
      req_op = 2'($urandom);
      req_a = $urandom;
      req_b = $urandom;
      fast = fast_path(op, a, b);
      if (fl_dly < 0) begin
         e.data = ref_model(op, a, b);
         e.acc_edge = acc;
         e.fast = fast;
         e.starts = core_starts;
         e.tag = tag;
         sb_q.push_back(e);
         n = 0;
         while (!rsp_valid && n < 200) begin
            rsp_ready = 1'($urandom);
            step();
            rsp_ready = 1'b0;
            n++;
         end
         if (!rsp_valid) begin
            chk({tag, " rsp_timeout"}, {31'b0, rsp_valid}, 32'd1);
            sb_q.delete();
            head_seen = 1'b0;
            return;
         end
         repeat (rdy_dly) step();
         rsp_ready = 1'b1;
         step();
         rsp_ready = 1'b0;
      end else begin
         flush_txn = 1'b1;
         rsp_ready = 1'b0;
         repeat (fl_dly) step();
         flush = 1'b1;
         fl_edge = cyc + 1;
         step();
         flush = 1'b0;
         #1;
         n = 0;
         saw = 1'b0;
         while (!req_ready && n < 100) begin
            if (rsp_valid) saw = 1'b1;
            step();
            n++;
         end
         chk({tag, " flush_no_rsp"}, {31'b0, saw}, 32'd0);
         rdy_exp = (fast || done_edge <= fl_edge) ? fl_edge : done_edge;
         chk({tag, " flush_ready_cycle"}, cyc, rdy_exp);
         flush_txn = 1'b0;
      end
   endtask

   function automatic logic [31:0] pick_operand(input bit divisor);
      case ($urandom_range(0, 7))
         0:       return divisor ? 32'h0 : 32'h80000000;
         1:       return 32'hFFFFFFFF;
         2:       return 32'($urandom_range(0, 20));
         3:       return -32'($urandom_range(1, 20));
         4:       return 32'h80000000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      repeat (3) step();
      chk("reset req_ready", {31'b0, req_ready}, 32'd0);
      chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("reset core_valid", {31'b0, core_valid}, 32'd0);
      chk("reset core_a", core_a, 32'd0);
      chk("reset core_b", core_b, 32'd0);
      chk("reset rsp_data", rsp_data, 32'd0);
      reset = 1'b0;
      #1;
      chk("release req_ready", {31'b0, req_ready}, 32'd1);
      step();

      core_lat = 2;
      do_req(2'd1, 32'd100, 32'd7, -1, 0, 1'b0, "divu_100_7");
      do_req(2'd3, 32'd100, 32'd7, -1, 1, 1'b0, "remu_100_7");
      do_req(2'd0, 32'hFFFFFFF9, 32'd2, -1, 0, 1'b0, "div_m7_2");
      do_req(2'd2, 32'hFFFFFFF9, 32'd2, -1, 0, 1'b0, "rem_m7_2");
      do_req(2'd0, 32'h12345678, 32'd0, -1, 0, 1'b0, "div_by_zero");
      do_req(2'd3, 32'h12345678, 32'd0, -1, 0, 1'b0, "remu_by_zero");
      do_req(2'd2, 32'hFFFFFF00, 32'd0, -1, 0, 1'b0, "rem_neg_by_zero");
      do_req(2'd0, 32'h80000000, 32'hFFFFFFFF, -1, 0, 1'b0, "div_overflow");
      do_req(2'd2, 32'h80000000, 32'hFFFFFFFF, -1, 0, 1'b0, "rem_overflow");
      do_req(2'd0, 32'h80000000, 32'd3, -1, 0, 1'b0, "div_intmin_3");
      core_lat = 4;
      do_req(2'd1, 32'd50, 32'd7, 1, 0, 1'b0, "divu_flush_wait");
      do_req(2'd1, 32'd50, 32'd7, 0, 0, 1'b0, "divu_flush_issue");
      do_req(2'd0, 32'd9, 32'd0, 2, 0, 1'b0, "div_flush_resp");
      do_req(2'd1, 32'd1000, 32'd10, -1, 5, 1'b0, "divu_rsp_stall");
      do_req(2'd1, 32'd3, 32'd9, -1, 0, 1'b0, "divu_small_3_9");
      do_req(2'd2, 32'hFFFFFFFD, 32'd9, -1, 0, 1'b1, "rem_small_preflush");

      core_lat = -1;
      for (int i = 0; i < 200; i++) begin
         logic [1:0]  op;
         logic [31:0] a, b;
         int          fl;
         op = 2'($urandom_range(0, 3));
         a = pick_operand(1'b0);
         b = pick_operand(1'b1);
         fl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 5) : -1;
         do_req(op, a, b, fl, $urandom_range(0, 3), ($urandom_range(0, 9) == 0), $sformatf("rnd%0d", i));
      end

      core_lat = 6;
      req_op = 2'd1;
      req_a = 32'd1000;
      req_b = 32'd3;
      req_valid = 1'b1;
      #1;
      while (!req_ready) step();
      step();
      req_valid = 1'b0;
      repeat (2) step();
      flush_txn = 1'b1;
      reset = 1'b1;
      step();
      chk("midreset rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("midreset core_valid", {31'b0, core_valid}, 32'd0);
      chk("midreset req_ready", {31'b0, req_ready}, 32'd0);
      reset = 1'b0;
      #1;
      chk("midreset release req_ready", {31'b0, req_ready}, 32'd1);
      flush_txn = 1'b0;
      core_lat = 1;
      do_req(2'd0, 32'hFFFFFF9C, 32'd7, -1, 0, 1'b0, "after_reset_div");
      repeat (3) step();
      chk("scoreboard_empty", sb_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
